// File: rtl/parallel_to_serial.sv
// parallel_to_serial
//   Width down-converter. Each accepted 2*DATA_W word is sent out as two
//   DATA_W beats. By default the low half goes first, and o_last marks the
//   second beat. There is a valid/ready handshake on both sides, and
//   consecutive words stream with no idle cycle between them.
//
//   Optional macro P2S_MSB_FIRST_EN: when it is defined, the high half of
//   each word is emitted first. o_last still marks the second beat.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-high reset
//   i_data   in   2*DATA_W input word
//   i_valid  in   input word valid
//   i_ready  out  block can accept a word this cycle (combinational)
//   clear    in   synchronous flush of any held word
//   o_data   out  DATA_W output beat (registered)
//   o_valid  out  o_data valid (registered)
//   o_ready  in   downstream accepts the beat this cycle
//   o_last   out  high on the second beat of each word (registered)

module parallel_to_serial #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*DATA_W-1:0]   i_data,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic                  clear,
  output logic [DATA_W-1:0]     o_data,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic                  o_last
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

  state_t                state;
  logic [2*DATA_W-1:0]   word_p0;
  logic                  accept;

  function automatic logic [DATA_W-1:0] first_half(input logic [2*DATA_W-1:0] w);
`ifdef P2S_MSB_FIRST_EN
    return w[2*DATA_W-1:DATA_W];
`else
    return w[DATA_W-1:0];
`endif
  endfunction

  function automatic logic [DATA_W-1:0] second_half(input logic [2*DATA_W-1:0] w);
`ifdef P2S_MSB_FIRST_EN
    return w[DATA_W-1:0];
`else
    return w[2*DATA_W-1:DATA_W];
`endif
  endfunction

  // A new word can be taken when nothing is held. It can also be taken while
  // the final beat is leaving, which is what removes the bubble between
  // consecutive words. The rst term keeps i_ready low for the whole reset
  // interval.
  assign i_ready = !rst && ((state == EMPTY) || ((state == SECOND) && o_ready));
  assign accept  = i_valid && i_ready;

  // Stage p0: capture the word and present its first half. Then step to the
  // second half when the first beat is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      word_p0 <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else if (clear) begin
      // The flush wins over any simultaneous accept or beat transfer. The
      // held word is left in place, but it is never emitted.
      state   <= EMPTY;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            word_p0 <= i_data;
            o_data  <= first_half(i_data);
            o_valid <= 1'b1;
            o_last  <= 1'b0;
            state   <= FIRST;
          end
        end
        FIRST: begin
          if (o_ready) begin
            o_data <= second_half(word_p0);
            o_last <= 1'b1;
            state  <= SECOND;
          end
        end
        SECOND: begin
          if (o_ready) begin
            if (accept) begin
              word_p0 <= i_data;
              o_data  <= first_half(i_data);
              o_valid <= 1'b1;
              o_last  <= 1'b0;
              state   <= FIRST;
            end else begin
              o_valid <= 1'b0;
              o_last  <= 1'b0;
              state   <= EMPTY;
            end
          end
        end
        default: begin
          // The unused encoding falls back to idle.
          o_valid <= 1'b0;
          o_last  <= 1'b0;
          state   <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// tb_parallel_to_serial
//   Scoreboard bench for parallel_to_serial. The driver pushes the two
//   expected beats of every accepted word, computed directly from the word.
//   A separate monitor pops one expected beat for each output transfer and
//   compares it. Build with +define+P2S_MSB_FIRST_EN to exercise the
//   high-half-first order.

module tb_parallel_to_serial;

  localparam int DATA_W = 32;

`ifdef P2S_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [2*DATA_W-1:0] i_data;
  logic                i_valid;
  logic                i_ready;
  logic                clear;
  logic [DATA_W-1:0]   o_data;
  logic                o_valid;
  logic                o_ready;
  logic                o_last;

  parallel_to_serial #(.DATA_W(DATA_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .clear   (clear),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_last  (o_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              l;
  } beat_t;

  beat_t exp_q[$];
  int    acc_cyc[$];
  int    beat_cyc[$];
  int    checks = 0;
  int    fails  = 0;
  int    cyc    = 0;
  bit    rnd_rdy = 1'b0;

  always @(posedge clk) cyc++;

  // Random back-pressure, applied only while the bench enables it.
  always @(posedge clk) begin
    #1;
    if (rnd_rdy) o_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: split the word into halves in emission order.
  function automatic void push_word(input logic [2*DATA_W-1:0] w);
    logic [DATA_W-1:0] lo, hi;
    beat_t b0, b1;
    lo = w[DATA_W-1:0];
    hi = w[2*DATA_W-1:DATA_W];
    b0.d = MSB_FIRST ? hi : lo;
    b0.l = 1'b0;
    b1.d = MSB_FIRST ? lo : hi;
    b1.l = 1'b1;
    exp_q.push_back(b0);
    exp_q.push_back(b1);
  endfunction

  // Monitor: compares each output transfer and checks that a stalled beat
  // does not change.
  logic              stall_prev = 1'b0;
  logic [DATA_W-1:0] prev_d;
  logic              prev_l;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 64'(o_valid), 64'd1);
        chk("stall_data", 64'(o_data), 64'(prev_d));
        chk("stall_last", 64'(o_last), 64'(prev_l));
      end
      if (o_valid && o_ready && !clear) begin
        beat_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_beat: got %0h, expected no beat (cycle %0d)", o_data, cyc);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", 64'(o_data), 64'(e.d));
          chk("beat_last", 64'(o_last), 64'(e.l));
        end
      end
      if (clear) exp_q.delete();
      stall_prev = o_valid && !o_ready && !clear;
      prev_d = o_data;
      prev_l = o_last;
    end
  end

  task automatic send(input logic [2*DATA_W-1:0] w);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    i_data  = w;
    i_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (i_ready && !clear) begin
        push_word(w);
        acc_cyc.push_back(cyc);
        done = 1'b1;
      end else begin
        n++;
        if (n > 200) begin
          checks++;
          fails++;
          $display("FAIL send_timeout: word %0h not accepted, expected accept within 200 cycles", w);
          done = 1'b1;
        end else begin
          @(posedge clk);
          #1;
        end
      end
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_data  = {$urandom, $urandom};
  endtask

  task automatic drain();
    int n;
    n = 0;
    o_ready = 1'b1;
    while ((exp_q.size() != 0 || o_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", 64'(n < 100), 64'd1);
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [63:0]       w;
    logic [DATA_W-1:0] f, s;
    int                b0, a0;

    // Reset, with i_valid held high the whole time
    rst = 1'b1; clear = 1'b0; o_ready = 1'b1; i_valid = 1'b1;
    i_data = {$urandom, $urandom};
    repeat (3) begin
      @(negedge clk);
      chk("rst_o_valid", 64'(o_valid), 64'd0);
      chk("rst_o_data", 64'(o_data), 64'd0);
      chk("rst_o_last", 64'(o_last), 64'd0);
      chk("rst_i_ready", 64'(i_ready), 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_i_ready", 64'(i_ready), 64'd1);
    chk("post_rst_o_valid", 64'(o_valid), 64'd0);
    @(posedge clk); #1;

    // Single word: exact beat values and timing
    w = 64'hAAAA_BBBB_1111_2222;
    f = MSB_FIRST ? 32'hAAAA_BBBB : 32'h1111_2222;
    s = MSB_FIRST ? 32'h1111_2222 : 32'hAAAA_BBBB;
    send(w);
    @(negedge clk);
    chk("single_b1_valid", 64'(o_valid), 64'd1);
    chk("single_b1_data", 64'(o_data), 64'(f));
    chk("single_b1_last", 64'(o_last), 64'd0);
    @(negedge clk);
    chk("single_b2_valid", 64'(o_valid), 64'd1);
    chk("single_b2_data", 64'(o_data), 64'(s));
    chk("single_b2_last", 64'(o_last), 64'd1);
    @(negedge clk);
    chk("single_idle_valid", 64'(o_valid), 64'd0);
    @(posedge clk); #1;
    drain();

    // Streaming: four words back to back
    b0 = beat_cyc.size();
    a0 = acc_cyc.size();
    o_ready = 1'b1;
    for (int k = 0; k < 4; k++) send({$urandom, $urandom});
    drain();
    chk("stream_beats", 64'(beat_cyc.size() - b0), 64'd8);
    if (beat_cyc.size() - b0 == 8)
      chk("stream_no_gap", 64'(beat_cyc[b0+7] - beat_cyc[b0]), 64'd7);
    if (acc_cyc.size() - a0 == 4)
      for (int k = 1; k < 4; k++)
        chk("stream_accept_spacing", 64'(acc_cyc[a0+k] - acc_cyc[a0+k-1]), 64'd2);

    // Back-pressure: stall in FIRST for 5 cycles, then random o_ready
    o_ready = 1'b0;
    w = {$urandom, $urandom};
    send(w);
    f = MSB_FIRST ? w[63:32] : w[31:0];
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 64'(o_valid), 64'd1);
      chk("bp_data", 64'(o_data), 64'(f));
      chk("bp_i_ready", 64'(i_ready), 64'd0);
    end
    @(posedge clk); #1;
    rnd_rdy = 1'b1;
    for (int k = 0; k < 100; k++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      send({$urandom, $urandom});
    end
    rnd_rdy = 1'b0;
    drain();

    // Clear while in SECOND with o_ready low and a word offered
    o_ready = 1'b0;
    send({$urandom, $urandom});
    o_ready = 1'b1;
    @(posedge clk); #1;
    o_ready = 1'b0;
    i_valid = 1'b1; i_data = {$urandom, $urandom}; clear = 1'b1;
    @(negedge clk);
    chk("clr_second_o_last", 64'(o_last), 64'd1);
    chk("clr_second_i_ready", 64'(i_ready), 64'd0);
    @(posedge clk); #1;
    clear = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    chk("clr_o_valid", 64'(o_valid), 64'd0);
    chk("clr_o_last", 64'(o_last), 64'd0);
    chk("clr_i_ready", 64'(i_ready), 64'd1);

    // Clear in EMPTY drops a word offered while i_ready is high
    @(posedge clk); #1;
    i_valid = 1'b1; i_data = {$urandom, $urandom}; clear = 1'b1;
    @(negedge clk);
    chk("clr_empty_i_ready", 64'(i_ready), 64'd1);
    @(posedge clk); #1;
    clear = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    chk("clr_drop_o_valid", 64'(o_valid), 64'd0);
    @(posedge clk); #1;
    send({$urandom, $urandom});
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
